// File: rtl/rob_pkg.sv
// Shared constants, entry layout and pointer helper for the reorder buffer.
package rob_pkg;

    localparam int Q_WIDTH_DEF        = 5;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int DEPTH              = 2**Q_WIDTH_DEF - 1;

    localparam logic [Q_WIDTH_DEF-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic                          valid;
        logic                          ready;
        logic                          has_rd;
        logic [REG_ADDR_WIDTH_DEF-1:0] rd;
        logic [31:0]                   value;
    } rob_entry_t;

    // Tags run 1..DEPTH; tag 0 means "value ready" and is never allocated.
    function automatic logic [Q_WIDTH_DEF-1:0] ptr_inc(input logic [Q_WIDTH_DEF-1:0] p);
        return (p == Q_WIDTH_DEF'(DEPTH)) ? Q_WIDTH_DEF'(1) : p + Q_WIDTH_DEF'(1);
    endfunction

endpackage

// File: rtl/rob_query_port.sv
// Operand lookup into the ROB by tag, with same-cycle forwarding from the CDB.
module rob_query_port #(
    parameter int Q_WIDTH = 5,
    parameter int DEPTH   = 31
) (
    input  logic [Q_WIDTH-1:0]    tag,
    input  logic [DEPTH:0]        valid_vec,
    input  logic [DEPTH:0]        ready_vec,
    input  logic [DEPTH:0][31:0]  value_vec,
    input  logic                  cdb_valid,
    input  logic [Q_WIDTH-1:0]    cdb_tag,
    input  logic [31:0]           cdb_value,
    output logic                  ready,
    output logic [31:0]           value
);

    logic fwd;

    assign fwd   = cdb_valid & (cdb_tag == tag) & (tag != '0);
    assign ready = fwd | ((tag != '0) & valid_vec[tag] & ready_vec[tag]);
    assign value = fwd ? cdb_value : value_vec[tag];

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: tag allocation, CDB capture, in-order commit.
// Optional ROB_BYPASS_EN lets the head retire in the cycle its result is on the CDB.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int Q_WIDTH        = Q_WIDTH_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_has_rd,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    output logic                      issue_ready,
    output logic [Q_WIDTH-1:0]        issue_tag,
    input  logic                      cdb_valid,
    input  logic [Q_WIDTH-1:0]        cdb_tag,
    input  logic [31:0]               cdb_value,
    input  logic [Q_WIDTH-1:0]        query1_tag,
    input  logic [Q_WIDTH-1:0]        query2_tag,
    output logic                      query1_ready,
    output logic                      query2_ready,
    output logic [31:0]               query1_value,
    output logic [31:0]               query2_value,
    output logic                      rd_control,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [Q_WIDTH-1:0]        Q_value,
    output logic                      has_commit,
    output logic [REG_ADDR_WIDTH-1:0] commit_target,
    output logic [Q_WIDTH-1:0]        Commit_Q,
    output logic [31:0]               Commit_V
);

    localparam logic [Q_WIDTH-1:0] FULL = Q_WIDTH'(DEPTH);

    // Entry 0 is never allocated; it stays zero so a tag-0 lookup reads "not pending".
    rob_entry_t rob_q [0:DEPTH];

    logic [Q_WIDTH-1:0] head, tail, count;
    logic               active, fire, cdb_hit, head_fwd, retire;
    rob_entry_t         head_e;

    logic [DEPTH:0]       valid_vec, ready_vec;
    logic [DEPTH:0][31:0] value_vec;

    assign active      = rdy_in & ~flush;
    assign issue_ready = active & (count != FULL);
    assign issue_tag   = tail;
    assign fire        = issue_valid & issue_ready;

    assign rd_control  = fire & issue_has_rd & (issue_rd != '0);
    assign rd          = rd_control ? issue_rd : '0;
    assign Q_value     = rd_control ? tail : '0;

    assign head_e  = rob_q[head];
    assign cdb_hit = cdb_valid & active & (cdb_tag != TAG_NONE) & rob_q[cdb_tag].valid;

`ifdef ROB_BYPASS_EN
    assign head_fwd = cdb_hit & (cdb_tag == head);
`else
    assign head_fwd = 1'b0;
`endif

    assign retire        = active & (count != '0) & head_e.valid & (head_e.ready | head_fwd);
    assign has_commit    = retire & head_e.has_rd & (head_e.rd != '0);
    assign commit_target = has_commit ? head_e.rd : '0;
    assign Commit_Q      = has_commit ? head : '0;
    assign Commit_V      = has_commit ? (head_e.ready ? head_e.value : cdb_value) : '0;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        value_vec = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            valid_vec[i] = rob_q[i].valid;
            ready_vec[i] = rob_q[i].ready;
            value_vec[i] = rob_q[i].value;
        end
    end

    rob_query_port #(.Q_WIDTH(Q_WIDTH), .DEPTH(DEPTH)) u_query1 (
        .tag(query1_tag), .valid_vec(valid_vec), .ready_vec(ready_vec), .value_vec(value_vec),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .ready(query1_ready), .value(query1_value)
    );

    rob_query_port #(.Q_WIDTH(Q_WIDTH), .DEPTH(DEPTH)) u_query2 (
        .tag(query2_tag), .valid_vec(valid_vec), .ready_vec(ready_vec), .value_vec(value_vec),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .ready(query2_ready), .value(query2_value)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= Q_WIDTH'(1);
            tail  <= Q_WIDTH'(1);
            count <= '0;
            for (int i = 0; i <= DEPTH; i++) rob_q[i] <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                head  <= Q_WIDTH'(1);
                tail  <= Q_WIDTH'(1);
                count <= '0;
                for (int i = 0; i <= DEPTH; i++) rob_q[i] <= '0;
            end else begin
                // Retire clears after capture so a bypassed head leaves no stale ready bit.
                if (cdb_hit) begin
                    rob_q[cdb_tag].ready <= 1'b1;
                    rob_q[cdb_tag].value <= cdb_value;
                end
                if (retire) begin
                    rob_q[head].valid <= 1'b0;
                    rob_q[head].ready <= 1'b0;
                    head              <= ptr_inc(head);
                end
                if (fire) begin
                    rob_q[tail] <= '{valid: 1'b1, ready: 1'b0, has_rd: issue_has_rd,
                                     rd: issue_rd, value: 32'h0};
                    tail        <= ptr_inc(tail);
                end
                case ({fire, retire})
                    2'b10:   count <= count + Q_WIDTH'(1);
                    2'b01:   count <= count - Q_WIDTH'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: program-order queue model checked every cycle plus literal pins.
module tb_rob_commit_ctrl;

    logic        clk_in, rst_in, rdy_in, flush;
    logic        issue_valid, issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  issue_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [4:0]  query1_tag, query2_tag;
    logic        query1_ready, query2_ready;
    logic [31:0] query1_value, query2_value;
    logic        rd_control;
    logic [4:0]  rd, Q_value;
    logic        has_commit;
    logic [4:0]  commit_target, Commit_Q;
    logic [31:0] Commit_V;

    rob_commit_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .query1_tag(query1_tag), .query2_tag(query2_tag),
        .query1_ready(query1_ready), .query2_ready(query2_ready),
        .query1_value(query1_value), .query2_value(query2_value),
        .rd_control(rd_control), .rd(rd), .Q_value(Q_value),
        .has_commit(has_commit), .commit_target(commit_target),
        .Commit_Q(Commit_Q), .Commit_V(Commit_V)
    );

    initial begin
        clk_in = 0;
        forever #5 clk_in = ~clk_in;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-flight tags in program order, plus per-tag result state.
    int          mq[$];
    bit          mvalid[32], mrdy[32], mhasrd[32];
    logic [4:0]  mrd[32];
    logic [31:0] mval[32];
    int          mtail;

    bit          e_issue_ready, e_fire, e_rd_control, e_retire, e_has_commit;
    int          e_head;
    logic [4:0]  e_rd, e_Q, e_target, e_cq;
    logic [31:0] e_cv;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) begin
            mvalid[i] = 0; mrdy[i] = 0; mhasrd[i] = 0; mrd[i] = 0; mval[i] = 0;
        end
        mtail = 1;
    endtask

    task automatic model_eval();
        bit hr;
        e_head        = (mq.size() > 0) ? mq[0] : mtail;
        e_issue_ready = rdy_in && !flush && (mq.size() < 31);
        e_fire        = issue_valid && e_issue_ready;
        e_rd_control  = e_fire && issue_has_rd && (issue_rd != 0);
        e_rd          = e_rd_control ? issue_rd : 5'd0;
        e_Q           = e_rd_control ? 5'(mtail) : 5'd0;
        hr = mrdy[e_head];
`ifdef ROB_BYPASS_EN
        if (cdb_valid && cdb_tag == 5'(e_head) && mvalid[e_head]) hr = 1;
`endif
        e_retire     = rdy_in && !flush && (mq.size() > 0) && hr;
        e_has_commit = e_retire && mhasrd[e_head] && (mrd[e_head] != 0);
        e_target     = e_has_commit ? mrd[e_head] : 5'd0;
        e_cq         = e_has_commit ? 5'(e_head) : 5'd0;
        e_cv         = e_has_commit ? (mrdy[e_head] ? mval[e_head] : cdb_value) : 32'd0;
    endtask

    function automatic bit q_ready(input logic [4:0] t);
        if (t == 0) return 0;
        return (cdb_valid && cdb_tag == t) || (mvalid[t] && mrdy[t]);
    endfunction

    function automatic logic [31:0] q_value(input logic [4:0] t);
        return (cdb_valid && cdb_tag == t) ? cdb_value : mval[t];
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) model_reset();
        else if (rdy_in) begin
            if (flush) model_reset();
            else begin
                model_eval();
                if (cdb_valid && cdb_tag != 0 && mvalid[cdb_tag]) begin
                    mrdy[cdb_tag] = 1;
                    mval[cdb_tag] = cdb_value;
                end
                if (e_retire) begin
                    void'(mq.pop_front());
                    mvalid[e_head] = 0;
                    mrdy[e_head]   = 0;
                end
                if (e_fire) begin
                    mq.push_back(mtail);
                    mvalid[mtail] = 1; mrdy[mtail] = 0;
                    mhasrd[mtail] = issue_has_rd; mrd[mtail] = issue_rd;
                    mtail = mtail % 31 + 1;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            model_eval();
            chk("m_issue_ready", 32'(issue_ready), 32'(e_issue_ready));
            chk("m_issue_tag", 32'(issue_tag), 32'(mtail));
            chk("m_rd_control", 32'(rd_control), 32'(e_rd_control));
            chk("m_rd", 32'(rd), 32'(e_rd));
            chk("m_Q_value", 32'(Q_value), 32'(e_Q));
            chk("m_has_commit", 32'(has_commit), 32'(e_has_commit));
            chk("m_commit_target", 32'(commit_target), 32'(e_target));
            chk("m_Commit_Q", 32'(Commit_Q), 32'(e_cq));
            chk("m_Commit_V", Commit_V, e_cv);
            chk("m_query1_ready", 32'(query1_ready), 32'(q_ready(query1_tag)));
            chk("m_query2_ready", 32'(query2_ready), 32'(q_ready(query2_tag)));
            if (q_ready(query1_tag)) chk("m_query1_value", query1_value, q_value(query1_tag));
            if (q_ready(query2_tag)) chk("m_query2_value", query2_value, q_value(query2_tag));
        end
    end

    int qsel = 0;

    task automatic set_idle();
        rdy_in = 1; flush = 0;
        issue_valid = 0; issue_has_rd = 0; issue_rd = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        set_idle();
        qsel++;
        query1_tag = 5'(qsel % 32);
        query2_tag = 5'((qsel * 7) % 32);
    endtask

    task automatic issue(input logic has, input logic [4:0] r);
        issue_valid = 1; issue_has_rd = has; issue_rd = r;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] v);
        cdb_valid = 1; cdb_tag = t; cdb_value = v;
    endtask

    initial begin
        set_idle();
        rdy_in = 0; rst_in = 1; query1_tag = 0; query2_tag = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_issue_tag", 32'(issue_tag), 32'd1);
        chk("rst_issue_ready", 32'(issue_ready), 32'd0);
        chk("rst_rd_control", 32'(rd_control), 32'd0);
        chk("rst_Q_value", 32'(Q_value), 32'd0);
        chk("rst_has_commit", 32'(has_commit), 32'd0);
        chk("rst_Commit_V", Commit_V, 32'd0);
        rst_in = 0;
        step();

        // Basic issue / complete / commit
        issue(1, 5); #1;
        chk("t1_rd_control", 32'(rd_control), 32'd1);
        chk("t1_Q_value", 32'(Q_value), 32'd1);
        chk("t1_issue_tag", 32'(issue_tag), 32'd1);
        step();
        cdb(1, 32'hDEADBEEF); #1;
`ifndef ROB_BYPASS_EN
        chk("t1_no_early_commit", 32'(has_commit), 32'd0);
        step(); #1;
`endif
        chk("t1_has_commit", 32'(has_commit), 32'd1);
        chk("t1_commit_target", 32'(commit_target), 32'd5);
        chk("t1_Commit_Q", 32'(Commit_Q), 32'd1);
        chk("t1_Commit_V", Commit_V, 32'hDEADBEEF);
        step();

        // Fill to 31, wrap, full stall despite retire, fire+retire at DEPTH-1
        flush = 1; step();
        for (int i = 0; i < 31; i++) begin
            issue(1, 5'(i + 1)); step();
        end
        issue(1, 9); #1;
        chk("t2_full_ready", 32'(issue_ready), 32'd0);
        chk("t2_full_rd_control", 32'(rd_control), 32'd0);
        chk("t2_full_tag", 32'(issue_tag), 32'd1);
        step();
        cdb(1, 32'h1111);
`ifndef ROB_BYPASS_EN
        step();
`endif
        #1;
        chk("t2_retire_when_full", 32'(has_commit), 32'd1);
        chk("t2_full_stall_on_retire", 32'(issue_ready), 32'd0);
        step();
        issue(1, 20); #1;
        chk("t2_wrap_tag", 32'(issue_tag), 32'd1);
        chk("t2_wrap_ready", 32'(issue_ready), 32'd1);
        chk("t2_wrap_Q_value", 32'(Q_value), 32'd1);
        step();
        cdb(2, 32'h2222); step();
`ifndef ROB_BYPASS_EN
        step();
        cdb(3, 32'h3333); step();
`else
        cdb(3, 32'h3333);
`endif
        issue(1, 21); #1;
        chk("t2_fire_and_retire_ready", 32'(issue_ready), 32'd1);
        chk("t2_fire_and_retire_commit", 32'(has_commit), 32'd1);
        chk("t2_fire_and_retire_q", 32'(Commit_Q), 32'd3);
        step();

        // Out-of-order completion
        flush = 1; step();
        issue(1, 1); step();
        issue(1, 2); step();
        issue(1, 3); step();
        cdb(3, 32'h33); #1; chk("t3_wait3", 32'(has_commit), 32'd0); step();
        cdb(2, 32'h22); #1; chk("t3_wait2", 32'(has_commit), 32'd0); step();
        #1; chk("t3_wait_idle", 32'(has_commit), 32'd0); step();
        cdb(1, 32'h11);
`ifndef ROB_BYPASS_EN
        #1; chk("t3_wait1", 32'(has_commit), 32'd0); step();
`endif
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("t3_ooo_commit", 32'(has_commit), 32'd1);
            chk("t3_ooo_q", 32'(Commit_Q), 32'(k));
            step();
        end

        // Silent retires: rd=0 and no-rd entries (tags 4,5), then tag 6 commits
        issue(1, 0); #1; chk("t4_rd0_ctrl", 32'(rd_control), 32'd0); step();
        issue(0, 7); #1; chk("t4_nord_ctrl", 32'(rd_control), 32'd0); step();
        issue(1, 9); #1; chk("t4_rd9_q", 32'(Q_value), 32'd6); step();
        cdb(4, 32'h44); #1; chk("t4_silent4", 32'(has_commit), 32'd0); step();
        cdb(5, 32'h55); #1; chk("t4_silent5", 32'(has_commit), 32'd0); step();
        cdb(6, 32'h66);
`ifndef ROB_BYPASS_EN
        #1; chk("t4_silent", 32'(has_commit), 32'd0); step();
`endif
        #1;
        chk("t4_commit6", 32'(has_commit), 32'd1);
        chk("t4_commit6_q", 32'(Commit_Q), 32'd6);
        chk("t4_commit6_tgt", 32'(commit_target), 32'd9);
        step();

        // Flush with a retireable head and a CDB hit
        flush = 1; step();
        for (int i = 1; i <= 4; i++) begin
            issue(1, 5'(i)); step();
        end
`ifndef ROB_BYPASS_EN
        cdb(1, 32'hA1); step();
        cdb(2, 32'hA2);
`else
        cdb(1, 32'hA1);
`endif
        flush = 1; issue(1, 7); #1;
        chk("t5_flush_commit", 32'(has_commit), 32'd0);
        chk("t5_flush_rd_control", 32'(rd_control), 32'd0);
        chk("t5_flush_issue_ready", 32'(issue_ready), 32'd0);
        step();
        query1_tag = 2; query2_tag = 1; #1;
        chk("t5_post_tag", 32'(issue_tag), 32'd1);
        chk("t5_post_ready", 32'(issue_ready), 32'd1);
        chk("t5_post_q1", 32'(query1_ready), 32'd0);
        chk("t5_post_q2", 32'(query2_ready), 32'd0);
        step();

        // Freeze with a ready head
        issue(1, 3); step();
        issue(1, 4); step();
        cdb(2, 32'hB2); step();
        cdb(1, 32'hB1);
`ifdef ROB_BYPASS_EN
        #1; chk("t6_bypass_commit", 32'(has_commit), 32'd1);
`endif
        step();
        for (int i = 0; i < 3; i++) begin
            rdy_in = 0; issue(1, 8); cdb(2, 32'h55); #1;
            chk("t6_freeze_commit", 32'(has_commit), 32'd0);
            chk("t6_freeze_ready", 32'(issue_ready), 32'd0);
            chk("t6_freeze_rd_control", 32'(rd_control), 32'd0);
            step();
        end
        #1;
        chk("t6_resume_commit", 32'(has_commit), 32'd1);
`ifdef ROB_BYPASS_EN
        chk("t6_resume_q", 32'(Commit_Q), 32'd2);
        chk("t6_resume_v", Commit_V, 32'hB2);
`else
        chk("t6_resume_q", 32'(Commit_Q), 32'd1);
        chk("t6_resume_v", Commit_V, 32'hB1);
`endif
        step();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
